pipe_skid_stage: RTL and testbench

- Parametrised successor to the single-register stall stage in the core pipeline.
- Replaces the global Stall input with a per-stage valid/ready handshake, backed by a one-entry skid buffer, so back-pressure no longer needs a combinational path through the stage.
- Adds flush with bubble insertion (configurable NOP) for branch and debug-halt redirects.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...) and between the debug-module instruction injector and decode.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_skid_stage.sv | 123 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage with one-entry skid buffer and flush
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] BUBBLE_VAL = RV_NOP
) (
    input  logic             clk,
    input  logic             reset_stages,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_VAL);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_fire, out_fire;

    // Handshake flags come straight from registers, so in_ready never sees out_ready.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        main_d  = BUBBLE;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occ_d       = 2'd0;
        case (state_d)
            ST_BUSY: begin
                out_valid_d = 1'b1;
                occ_d       = 2'd1;
            end
            ST_FULL: begin
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
                occ_d       = 2'd2;
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                occ_d       = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_stages) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occ_q       <= occ_d;
        end
    end

    // main is reloaded with the bubble whenever the stage empties, so it can drive out_data directly.
    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_stages, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(32), .BUBBLE_VAL(NOP)) dut (
        .clk          (clk),
        .reset_stages (reset_stages),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .occupancy    (occupancy)
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [31:0] id, logic ordy,
                                logic e_ov, logic [31:0] e_od, logic e_ir, logic [1:0] e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] id, input logic ordy);
        reset_stages = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    endtask

    logic [31:0] model_q[$];
    logic        m_ir, m_ov;
    logic [31:0] m_od;
    logic        r_rst, r_fl, r_iv, r_or;
    logic [31:0] r_d;
    int          rnd_fail_prints;
    bit          ok;

    initial begin
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // reset held two cycles with live input
        vecs.push_back(mk(1, 0, 1, 32'hDEAD_BEEF, 0, 0, NOP,          1, 0));
        vecs.push_back(mk(1, 0, 1, 32'hDEAD_BEEF, 0, 0, NOP,          1, 0));
        // streaming, occupancy stays at 1
        vecs.push_back(mk(0, 0, 1, 32'h1,         1, 1, 32'h1,        1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h2,         1, 1, 32'h2,        1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h3,         1, 1, 32'h3,        1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, NOP,          1, 0));
        // skid fill, ignored push while full, drain
        vecs.push_back(mk(0, 0, 1, 32'hA,         0, 1, 32'hA,        1, 1));
        vecs.push_back(mk(0, 0, 1, 32'hB,         0, 1, 32'hA,        0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h77,        0, 1, 32'hA,        0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'hB,        1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, NOP,          1, 0));
        // flush while full discards C
        vecs.push_back(mk(0, 0, 1, 32'hA,         0, 1, 32'hA,        1, 1));
        vecs.push_back(mk(0, 0, 1, 32'hB,         0, 1, 32'hA,        0, 2));
        vecs.push_back(mk(0, 1, 1, 32'hC,         0, 0, NOP,          1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, NOP,          1, 0));
        // flush while busy with simultaneous in_fire and out_fire
        vecs.push_back(mk(0, 0, 1, 32'h5,         0, 1, 32'h5,        1, 1));
        vecs.push_back(mk(0, 1, 1, 32'h6,         1, 0, NOP,          1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, NOP,          1, 0));
        // reset and flush together while busy
        vecs.push_back(mk(0, 0, 1, 32'h9,         0, 1, 32'h9,        1, 1));
        vecs.push_back(mk(1, 1, 1, 32'h10,        0, 0, NOP,          1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, NOP,          1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            step();
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
            check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
            check($sformatf("vec%0d occupancy", i), {30'b0, occupancy}, {30'b0, vecs[i].e_occ});
        end

        // in_ready must not move with out_ready inside a cycle while full
        drive(0, 0, 1, 32'h21, 0); step();
        drive(0, 0, 1, 32'h22, 0); step();
        check("full in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1; #2;
        check("comb in_ready", {31'b0, in_ready}, 32'd0);
        check("comb out_data", out_data, 32'h21);
        in_valid = 1'b0; step();
        check("drain1 data", out_data, 32'h22);
        step();
        check("drain2 valid", {31'b0, out_valid}, 32'd0);

        // randomised traffic against a two-entry FIFO model
        drive(1, 0, 0, 0, 0); step();
        model_q.delete();
        rnd_fail_prints = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r_rst = ($urandom_range(0, 499) == 0);
            r_fl  = ($urandom_range(0, 99) == 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_or  = ($urandom_range(0, 2) != 0);
            r_d   = $urandom;
            drive(r_rst, r_fl, r_iv, r_d, r_or);
            #1;
            m_ir = (model_q.size() < 2);
            m_ov = (model_q.size() != 0);
            m_od = m_ov ? model_q[0] : NOP;
            ok = (in_ready === m_ir) && (out_valid === m_ov) && (out_data === m_od) &&
                 (occupancy === 2'(model_q.size()));
            checks++;
            if (!ok) begin
                failures++;
                if (rnd_fail_prints < 20) begin
                    rnd_fail_prints++;
                    $display("FAIL random cyc%0d: got v=%b d=%h r=%b occ=%0d expected v=%b d=%h r=%b occ=%0d",
                             cyc, out_valid, out_data, in_ready, occupancy,
                             m_ov, m_od, m_ir, model_q.size());
                end
            end
            if (r_rst || r_fl) begin
                model_q.delete();
            end else begin
                if (r_or && m_ov) void'(model_q.pop_front());
                if (r_iv && m_ir) model_q.push_back(r_d);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
